// File: rtl/fpu_add_responder.sv
// fpu_add_responder
//   Responder side of the FPU operand/result handshake. Captures two
//   IEEE-754 binary32 operands and an opcode, computes add or subtract
//   over several cycles (UNPACK, ALIGN, NORM) with round-toward-zero,
//   then holds the result until the requester acknowledges it.
//
// Handshake: the requester raises input_rdy with valid operands. In IDLE
//   the responder captures them on that edge and pulses input_ack for the
//   following cycle; input_rdy is ignored in every other state. The
//   result is valid while output_rdy is high and stays stable until
//   output_ack is sampled high, after which output_rdy drops on that edge
//   and the FSM returns to IDLE. output_ack is ignored outside DONE.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   operation   opcode, sampled with the operands
//   data_a      operand A (binary32)
//   data_b      operand B (binary32)
//   input_rdy   requester: operands/opcode valid
//   input_ack   operands captured (one-cycle pulse)
//   result      binary32 result, valid while output_rdy
//   output_rdy  result valid, held until output_ack
//   output_ack  requester: result consumed
//   fsm_state   current FSM state (debug observation)
module fpu_add_responder #(
  parameter logic [3:0]  OP_ADD = 4'b0000,
  parameter logic [3:0]  OP_SUB = 4'b0001,
  parameter logic [31:0] QNAN   = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  operation,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        input_rdy,
  output logic        input_ack,
  output logic [31:0] result,
  output logic        output_rdy,
  input  logic        output_ack,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    NORM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  // captured operands; B already carries the subtract sign flip
  logic [31:0] a_q, b_q;
  logic        op_bad;

  // aligned operand pair, larger magnitude first
  logic        big_sign;
  logic [7:0]  big_exp;
  logic [26:0] big_sig, small_sig;
  logic [7:0]  exp_diff;
  logic        eff_sub;
  logic [27:0] sum_q;

  assign fsm_state = state;

  // ---------------- operand classification (UNPACK) ----------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        is_special;
  logic [31:0] special_val;
  logic        b_bigger;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign fa     = a_q[22:0];
  assign fb     = b_q[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  // denormals are treated as signed zero
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  // exponent then mantissa ordering is exactly the unsigned order of bits 30:0
  assign b_bigger = (b_q[30:0] > a_q[30:0]);

  always_comb begin
    is_special  = 1'b1;
    special_val = QNAN;
    if (op_bad || a_nan || b_nan) begin
      special_val = QNAN;
    end else if (a_inf && b_inf) begin
      special_val = (a_q[31] != b_q[31]) ? QNAN : a_q;
    end else if (a_inf) begin
      special_val = a_q;
    end else if (b_inf) begin
      special_val = b_q;
    end else if (a_zero && b_zero) begin
      // only (-0)+(-0) keeps the negative sign
      special_val = {a_q[31] & b_q[31], 31'd0};
    end else if (a_zero) begin
      special_val = b_q;
    end else if (b_zero) begin
      special_val = a_q;
    end else begin
      is_special = 1'b0;
    end
  end

  // ---------------- alignment and add/sub (ALIGN) ----------------
  logic [26:0] shifted;
  logic [27:0] sum_next;

  always_comb begin
    shifted  = (exp_diff >= 8'd27) ? 27'd0 : (small_sig >> exp_diff);
    sum_next = eff_sub ? ({1'b0, big_sig} - {1'b0, shifted})
                       : ({1'b0, big_sig} + {1'b0, shifted});
  end

  // ---------------- normalise and pack (NORM) ----------------
  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       norm_mant;
  logic signed [9:0] norm_exp;
  logic [31:0]       pack_val;

  always_comb begin
    lzc      = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum_q[i]) lz_found = 1'b1;
        else          lzc = lzc + 5'd1;
      end
    end

    if (sum_q[27]) begin
      norm_mant = sum_q[27:1];
      norm_exp  = signed'({2'b00, big_exp}) + 10'sd1;
    end else begin
      norm_mant = sum_q[26:0] << lzc;
      norm_exp  = signed'({2'b00, big_exp}) - signed'({5'b00000, lzc});
    end

    if (sum_q == 28'd0) begin
      pack_val = 32'd0;                          // exact cancellation is +0
    end else if (norm_exp >= 10'sd255) begin
      pack_val = {big_sign, 8'hFF, 23'd0};
    end else if (norm_exp <= 10'sd0) begin
      pack_val = 32'd0;                          // underflow flushed to +0
    end else begin
      pack_val = {big_sign, norm_exp[7:0], norm_mant[25:3]};
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (input_rdy) state_next = UNPACK;
      UNPACK:  state_next = is_special ? DONE : ALIGN;
      ALIGN:   state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    if (output_rdy && output_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath and output registers ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      input_ack  <= 1'b0;
      output_rdy <= 1'b0;
      result     <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_bad     <= 1'b0;
      big_sign   <= 1'b0;
      big_exp    <= 8'd0;
      big_sig    <= 27'd0;
      small_sig  <= 27'd0;
      exp_diff   <= 8'd0;
      eff_sub    <= 1'b0;
      sum_q      <= 28'd0;
    end else begin
      input_ack <= (state == IDLE) && input_rdy;
      case (state)
        IDLE: begin
          if (input_rdy) begin
            a_q    <= data_a;
            b_q    <= (operation == OP_SUB) ? {~data_b[31], data_b[30:0]} : data_b;
            op_bad <= (operation != OP_ADD) && (operation != OP_SUB);
          end
        end
        UNPACK: begin
          if (is_special) begin
            result <= special_val;
          end else if (b_bigger) begin
            big_sign  <= b_q[31];
            big_exp   <= eb;
            big_sig   <= {1'b1, fb, 3'b000};
            small_sig <= {1'b1, fa, 3'b000};
            exp_diff  <= eb - ea;
            eff_sub   <= a_q[31] ^ b_q[31];
          end else begin
            big_sign  <= a_q[31];
            big_exp   <= ea;
            big_sig   <= {1'b1, fa, 3'b000};
            small_sig <= {1'b1, fb, 3'b000};
            exp_diff  <= ea - eb;
            eff_sub   <= a_q[31] ^ b_q[31];
          end
        end
        ALIGN: sum_q <= sum_next;
        NORM:  result <= pack_val;
        DONE: begin
          // first DONE cycle raises output_rdy; the ack edge drops it
          if (output_rdy && output_ack) output_rdy <= 1'b0;
          else                          output_rdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
